// File: rtl/arbiter_control.sv
// arbiter_control: round-robin owner of the shared pmem port for the I/D caches,
// with writeback/refill locking, saturating grant counters and a stuck-transaction watchdog.
module arbiter_control #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023,
    parameter bit LOCK_WB = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iread,
    input  logic             dread,
    input  logic             dwrite,
    input  logic             pmem_resp,
    output logic             cache_sel,
    output logic             arb_busy,
    output logic [CNT_W-1:0] i_grants,
    output logic [CNT_W-1:0] d_grants,
    output logic             timeout
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] T_MAX  = WW'(TIMEOUT);
    localparam logic [WW-1:0] T_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, GAP} state_t;

    state_t           state_q, state_d;
    logic             last_d_q, last_d_d;
    logic             wb_lock_q, wb_lock_d;
    logic             timeout_q, timeout_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] ig_q, ig_d, dg_q, dg_d;
    logic             dreq, req_any, grant_d, grant, serving, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            wb_lock_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
            ig_q      <= '0;
            dg_q      <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            wb_lock_q <= wb_lock_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
            ig_q      <= ig_d;
            dg_q      <= dg_d;
        end
    end

    // A simultaneous dread+dwrite is a write, so it never qualifies for the refill lock.
    always_comb begin
        dreq    = dread | dwrite;
        req_any = iread | dreq;
        grant_d = dreq & (~iread | ~last_d_q | (wb_lock_q & dread & ~dwrite));
        grant   = (state_q == IDLE) & req_any;
        serving = (state_q == SERVE_I) | (state_q == SERVE_D);
        done    = serving & pmem_resp;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:             state_d = req_any ? (grant_d ? SERVE_D : SERVE_I) : IDLE;
            SERVE_I, SERVE_D: state_d = pmem_resp ? GAP : state_q;
            default:          state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d_d  = done ? (state_q == SERVE_D) : last_d_q;
        wb_lock_d = done ? (LOCK_WB & (state_q == SERVE_D) & dwrite) : (grant ? 1'b0 : wb_lock_q);
        wait_d    = done ? '0 : ((serving && wait_q != T_MAX) ? wait_q + WW'(1) : wait_q);
        timeout_d = timeout_q | (serving & ~pmem_resp & (wait_q == T_LAST));
        ig_d      = (grant & ~grant_d & ~&ig_q) ? ig_q + CNT_W'(1) : ig_q;
        dg_d      = (grant & grant_d & ~&dg_q) ? dg_q + CNT_W'(1) : dg_q;
    end

    always_comb begin
        cache_sel = last_d_q;
        case (state_q)
            IDLE:    cache_sel = req_any ? grant_d : last_d_q;
            SERVE_I: cache_sel = 1'b0;
            SERVE_D: cache_sel = 1'b1;
            default: cache_sel = last_d_q;
        endcase
        arb_busy = serving;
        i_grants = ig_q;
        d_grants = dg_q;
        timeout  = timeout_q;
    end
endmodule

// File: tb/tb_arbiter_control.sv
// tb_arbiter_control: vector-table bench comparing a LOCK_WB=1 and a LOCK_WB=0 arbiter
// (CNT_W=2, TIMEOUT=8) against hand-derived per-cycle expectations.
module tb_arbiter_control;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       iread = 1'b0, dread = 1'b0, dwrite = 1'b0, pmem_resp = 1'b0;
    logic       sel_a, busy_a, to_a, sel_b, busy_b, to_b;
    logic [1:0] ig_a, dg_a, ig_b, dg_b;

    always #5 clk = ~clk;

    arbiter_control #(.CNT_W(2), .TIMEOUT(8), .LOCK_WB(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .iread(iread), .dread(dread), .dwrite(dwrite),
        .pmem_resp(pmem_resp), .cache_sel(sel_a), .arb_busy(busy_a),
        .i_grants(ig_a), .d_grants(dg_a), .timeout(to_a));

    arbiter_control #(.CNT_W(2), .TIMEOUT(8), .LOCK_WB(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .iread(iread), .dread(dread), .dwrite(dwrite),
        .pmem_resp(pmem_resp), .cache_sel(sel_b), .arb_busy(busy_b),
        .i_grants(ig_b), .d_grants(dg_b), .timeout(to_b));

    // One row per cycle: inputs, then expected A/B select+busy and A counters/timeout (to<0: skip).
    typedef struct {
        bit rst;
        bit i, dr, dw, p;
        bit sa, ba, sb, bb;
        int ig, dg, to;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t v(input bit i, dr, dw, p, sa, ba, sb, bb, input int ig, dg, to);
        vec_t e;
        e.rst = 1'b0; e.i = i; e.dr = dr; e.dw = dw; e.p = p;
        e.sa = sa; e.ba = ba; e.sb = sb; e.bb = bb;
        e.ig = ig; e.dg = dg; e.to = to;
        return e;
    endfunction

    function automatic vec_t rs();
        vec_t e;
        e = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.rst = 1'b1;
        return e;
    endfunction

    task automatic do_reset(input int idx);
        @(negedge clk);
        #3;
        {iread, dread, dwrite, pmem_resp} = 4'b0;
        rst_n = 1'b0;
        #1;
        chk($sformatf("row%0d rst sel_a", idx), int'(sel_a), 1);
        chk($sformatf("row%0d rst busy_a", idx), int'(busy_a), 0);
        chk($sformatf("row%0d rst ig_a", idx), int'(ig_a), 0);
        chk($sformatf("row%0d rst dg_a", idx), int'(dg_a), 0);
        chk($sformatf("row%0d rst to_a", idx), int'(to_a), 0);
        chk($sformatf("row%0d rst sel_b", idx), int'(sel_b), 1);
        chk($sformatf("row%0d rst busy_b", idx), int'(busy_b), 0);
        chk($sformatf("row%0d rst cnt_b", idx), int'({ig_b, dg_b}), 0);
        chk($sformatf("row%0d rst to_b", idx), int'(to_b), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input vec_t e, input int idx);
        vec_t x;
        @(negedge clk);
        iread = e.i; dread = e.dr; dwrite = e.dw; pmem_resp = e.p;
        sb_q.push_back(e);
        #2;
        x = sb_q.pop_front();
        chk($sformatf("row%0d sel_a", idx), int'(sel_a), int'(x.sa));
        chk($sformatf("row%0d busy_a", idx), int'(busy_a), int'(x.ba));
        chk($sformatf("row%0d sel_b", idx), int'(sel_b), int'(x.sb));
        chk($sformatf("row%0d busy_b", idx), int'(busy_b), int'(x.bb));
        chk($sformatf("row%0d ig_a", idx), int'(ig_a), x.ig);
        chk($sformatf("row%0d dg_a", idx), int'(dg_a), x.dg);
        if (x.to >= 0) chk($sformatf("row%0d to_a", idx), int'(to_a), x.to);
    endtask

    initial begin
        // Single I request: same-cycle select, then SERVE_I.
        tbl.push_back(rs());
        tbl.push_back(v(1,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(1,0,0,0, 0,1,0,1, 1,0,0));
        tbl.push_back(v(1,0,0,1, 0,1,0,1, 1,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 1,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 1,0,0));
        // Held I+D reads alternate I,D,I,D.
        tbl.push_back(rs());
        tbl.push_back(v(1,1,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(1,1,0,1, 0,1,0,1, 1,0,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,0, 1,0,0));
        tbl.push_back(v(1,1,0,0, 1,0,1,0, 1,0,0));
        tbl.push_back(v(1,1,0,1, 1,1,1,1, 1,1,0));
        tbl.push_back(v(1,1,0,0, 1,0,1,0, 1,1,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,0, 1,1,0));
        tbl.push_back(v(1,1,0,1, 0,1,0,1, 2,1,0));
        tbl.push_back(v(1,1,0,0, 0,0,0,0, 2,1,0));
        tbl.push_back(v(1,1,0,0, 1,0,1,0, 2,1,0));
        tbl.push_back(v(1,1,0,1, 1,1,1,1, 2,2,0));
        tbl.push_back(v(0,0,0,0, 1,0,1,0, 2,2,0));
        tbl.push_back(v(0,0,0,0, 1,0,1,0, 2,2,0));
        // Writeback (dread+dwrite counts as write) then tie: A locks to D, B goes to I.
        tbl.push_back(rs());
        tbl.push_back(v(0,1,1,0, 1,0,1,0, 0,0,0));
        tbl.push_back(v(0,1,1,1, 1,1,1,1, 0,1,0));
        tbl.push_back(v(1,1,0,0, 1,0,1,0, 0,1,0));
        tbl.push_back(v(1,1,0,0, 1,0,0,0, 0,1,0));
        tbl.push_back(v(1,1,0,1, 1,1,0,1, 0,2,0));
        tbl.push_back(v(1,1,0,0, 1,0,0,0, 0,2,0));
        tbl.push_back(v(1,1,0,0, 0,0,1,0, 0,2,0));
        tbl.push_back(v(0,0,0,1, 0,1,1,1, 1,2,0));
        tbl.push_back(v(0,0,0,0, 0,0,1,0, 1,2,0));
        // Watchdog: no resp for 8 SERVE_D cycles, sticky afterwards.
        tbl.push_back(rs());
        tbl.push_back(v(0,1,0,0, 1,0,1,0, 0,0,0));
        for (int k = 1; k <= 7; k++) tbl.push_back(v(0,1,0,0, 1,1,1,1, 0,1,0));
        tbl.push_back(v(0,1,0,0, 1,1,1,1, 0,1,-1));
        tbl.push_back(v(0,1,0,0, 1,1,1,1, 0,1,1));
        tbl.push_back(v(0,1,0,1, 1,1,1,1, 0,1,1));
        tbl.push_back(v(0,0,0,0, 1,0,1,0, 0,1,1));
        tbl.push_back(v(0,0,0,0, 1,0,1,0, 0,1,1));
        // Asynchronous reset in the middle of SERVE_D.
        tbl.push_back(v(0,1,0,0, 1,0,1,0, 0,1,1));
        tbl.push_back(v(0,1,0,0, 1,1,1,1, 0,2,1));
        tbl.push_back(rs());
        // Five I grants saturate the 2-bit counter; stray resp in IDLE does nothing.
        for (int g = 0; g < 5; g++) begin
            tbl.push_back(v(1,0,0,0, 0,0,0,0, (g > 3) ? 3 : g, 0, 0));
            tbl.push_back(v(0,0,0,1, 0,1,0,1, (g + 1 > 3) ? 3 : g + 1, 0, 0));
            tbl.push_back(v(0,0,0,0, 0,0,0,0, (g + 1 > 3) ? 3 : g + 1, 0, 0));
        end
        tbl.push_back(v(0,0,0,1, 0,0,0,0, 3,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 3,0,0));

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset(k);
            else step(tbl[k], k);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
